// File: rtl/trace_tx_arbiter.sv
// trace_tx_arbiter
//
// Shares one 8N1 trace UART line between NREQ byte producers. Each producer offers a
// byte on a valid/ready pair. In IDLE a round-robin arbiter (searching from the
// requester after the last winner) raises a single ready strobe. The accepted byte
// is then serialised as start bit, 8 data bits LSB first, and stop bit. Each bit is
// exactly DIV = CLK_FREQ/BAUD clock cycles long.
//
// Parameters:
//   CLK_FREQ     clock frequency in Hz
//   BAUD         line rate; DIV = CLK_FREQ/BAUD (truncated, must be >= 2)
//   NREQ         number of requesters, 2..4
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   req_valid_i  per-requester byte valid
//   req_data_i   per-requester byte, requester k in bits [8k+7:8k]
//   req_ready_o  accept strobe, one-hot or zero, only ever high in IDLE
//   grant_o      one-hot owner of the frame in flight, zero when idle
//   busy_o       frame in progress
//   tx_o         serial output, idles high

module trace_tx_arbiter #(
   parameter int unsigned CLK_FREQ = 48_000_000,
   parameter int unsigned BAUD     = 115_200,
   parameter int unsigned NREQ     = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NREQ-1:0]     req_valid_i,
   input  logic [8*NREQ-1:0]   req_data_i,
   output logic [NREQ-1:0]     req_ready_o,
   output logic [NREQ-1:0]     grant_o,
   output logic                busy_o,
   output logic                tx_o
);

   localparam int unsigned DIV = CLK_FREQ / BAUD;
   localparam int unsigned CW  = $clog2(DIV);
   localparam int unsigned LW  = $clog2(NREQ);

   localparam logic [CW-1:0] BaudLast = CW'(DIV - 1);
   localparam logic [LW-1:0] LastInit = LW'(NREQ - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic [LW-1:0]     last_q, last_d;
   logic [NREQ-1:0]   grant_q, grant_d;

   logic              found;
   logic [LW-1:0]     winner;
   logic [LW:0]       cand;
   logic [LW-1:0]     idx;
   logic [7:0]        sel_data;
   logic [NREQ-1:0]   winner_oh;
   logic              fire;
   logic              baud_end;

   // Round-robin search: offsets 1..NREQ from the last winner, wrapping modulo NREQ.
   // The final offset revisits the last winner itself, so a lone requester can be
   // served back to back.
   always_comb begin
      found  = 1'b0;
      winner = last_q;
      cand   = '0;
      idx    = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         cand = {1'b0, last_q} + (LW+1)'(off);
         if (cand >= (LW+1)'(NREQ)) begin
            cand = cand - (LW+1)'(NREQ);
         end
         idx = cand[LW-1:0];
         if (!found && req_valid_i[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         if (winner == LW'(k)) begin
            sel_data = req_data_i[8*k +: 8];
         end
      end
   end

   assign winner_oh = NREQ'(1) << winner;
   assign fire      = (state_q == StIdle) && found;
   assign baud_end  = (baud_q == BaudLast);

   // Ready is combinational on valid; it is masked during reset so that valids held
   // high while reset is asserted never see a handshake.
   assign req_ready_o = (fire && rst_ni) ? winner_oh : '0;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      last_d  = last_q;
      grant_d = grant_q;
      unique case (state_q)
         StIdle: begin
            if (fire) begin
               state_d = StStart;
               baud_d  = '0;
               bit_d   = '0;
               shift_d = sel_data;
               last_d  = winner;
               grant_d = winner_oh;
            end
         end
         StStart: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = StData;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StData: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               // 3-bit counter wraps 7 -> 0 as the last data bit ends.
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StStop: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = StIdle;
               grant_d = '0;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         last_q  <= LastInit;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         grant_q <= grant_d;
      end
   end

   // tx is decoded from the state register, so an asynchronous reset forces the
   // line high immediately.
   always_comb begin
      case (state_q)
         StStart: tx_o = 1'b0;
         StData:  tx_o = shift_q[0];
         default: tx_o = 1'b1;
      endcase
   end

   assign busy_o  = (state_q != StIdle);
   assign grant_o = grant_q;

endmodule

// File: tb/tb_trace_tx_arbiter.sv
// Testbench for trace_tx_arbiter with DIV = 4. It uses a 2-requester and a
// 3-requester instance. A per-cycle vector table pins down the single-byte frame. A
// line monitor decodes every frame on the selected instance and checks it against a
// scoreboard queue of expected {byte, grant}.

module tb_trace_tx_arbiter;

   localparam int unsigned CF = 16;
   localparam int unsigned BD = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst2_n, rst3_n;
   logic [1:0]  valid2, ready2, grant2;
   logic [15:0] data2;
   logic        busy2, tx2;
   logic [2:0]  valid3, ready3, grant3;
   logic [23:0] data3;
   logic        busy3, tx3;

   trace_tx_arbiter #(.CLK_FREQ(CF), .BAUD(BD), .NREQ(2)) dut2 (
      .clk_i       (clk),
      .rst_ni      (rst2_n),
      .req_valid_i (valid2),
      .req_data_i  (data2),
      .req_ready_o (ready2),
      .grant_o     (grant2),
      .busy_o      (busy2),
      .tx_o        (tx2)
   );

   trace_tx_arbiter #(.CLK_FREQ(CF), .BAUD(BD), .NREQ(3)) dut3 (
      .clk_i       (clk),
      .rst_ni      (rst3_n),
      .req_valid_i (valid3),
      .req_data_i  (data3),
      .req_ready_o (ready3),
      .grant_o     (grant3),
      .busy_o      (busy3),
      .tx_o        (tx3)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_now  = 0;
   always @(posedge clk) cyc_now <= cyc_now + 1;

   typedef struct {
      logic [7:0] data;
      logic [3:0] grant;
   } exp_t;
   exp_t sb_q[$];
   int   start_q[$];

   logic       sel3 = 1'b0;
   logic       mon_tx, mon_busy, mon_rst_n;
   logic [3:0] mon_grant;
   bit         mon_in_frame = 1'b0;
   assign mon_tx    = sel3 ? tx3 : tx2;
   assign mon_busy  = sel3 ? busy3 : busy2;
   assign mon_rst_n = sel3 ? rst3_n : rst2_n;
   assign mon_grant = sel3 ? {1'b0, grant3} : {2'b00, grant2};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   // Frame complete (cycle 41 after acceptance): decode 10 groups of 4 samples.
   task automatic finish_frame(input logic [39:0] line, input logic [3:0] fgrant,
                               input bit held_ok);
      logic [3:0] grp;
      logic [9:0] bits;
      bit         timing_ok;
      exp_t       e;
      timing_ok = 1'b1;
      bits = '0;
      for (int g = 0; g < 10; g++) begin
         grp = line[4*g +: 4];
         if (grp != 4'h0 && grp != 4'hF) timing_ok = 1'b0;
         bits[g] = grp[0];
      end
      check("frame timing/start/stop", {29'd0, timing_ok, bits[0], bits[9]}, 32'd5);
      check("frame busy+grant held", {31'd0, held_ok}, 32'd1);
      check("frame idle after stop", {26'd0, mon_tx, mon_busy, mon_grant}, 32'h20);
      if (sb_q.size() == 0) begin
         n_checks++;
         $display("FAIL unexpected frame: actual data %0h grant %0h required none",
                  bits[8:1], fgrant);
      end else begin
         e = sb_q.pop_front();
         check("frame data", {24'd0, bits[8:1]}, {24'd0, e.data});
         check("frame grant", {28'd0, fgrant}, {28'd0, e.grant});
      end
   endtask

   initial begin : monitor
      int         c;
      logic [39:0] line;
      logic [3:0]  fgrant;
      bit          held_ok;
      c = 0; line = '0; fgrant = '0; held_ok = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_rst_n) begin
            mon_in_frame = 1'b0;
         end else if (!mon_in_frame) begin
            if (mon_tx == 1'b0) begin
               mon_in_frame = 1'b1;
               c = 1;
               line = {mon_tx, 39'd0};
               fgrant = mon_grant;
               held_ok = mon_busy;
               start_q.push_back(cyc_now);
            end
         end else begin
            c++;
            if (c <= 40) begin
               line = {mon_tx, line[39:1]};
               if (!mon_busy || mon_grant !== fgrant) held_ok = 1'b0;
            end else begin
               finish_frame(line, fgrant, held_ok);
               mon_in_frame = 1'b0;
            end
         end
      end
   end

   function automatic bit accept_now();
      return sel3 ? (|(ready3 & valid3)) : (|(ready2 & valid2));
   endfunction

   // Called at posedge+1; returns at posedge+1 of the first cycle after acceptance.
   task automatic wait_accept(input string name);
      int n = 0;
      #1;
      while (!accept_now() && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      check({name, " accept"}, {31'd0, accept_now()}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      #1;
      while ((sb_q.size() != 0 || mon_busy || mon_in_frame) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, " drained"}, 32'(sb_q.size()), 32'd0);
   endtask

   typedef struct {
      logic       valid;
      logic       exp_tx;
      logic       exp_busy;
      logic [1:0] exp_grant;
      logic [1:0] exp_ready;
   } vec_t;
   vec_t vec[43];
   bit   txseq[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      // Single-byte vector table: cycle 0 is the acceptance cycle.
      for (int c = 0; c < 43; c++) begin
         vec[c].valid     = (c == 0);
         vec[c].exp_ready = (c == 0) ? 2'b01 : 2'b00;
         vec[c].exp_busy  = (c >= 1 && c <= 40);
         vec[c].exp_grant = vec[c].exp_busy ? 2'b01 : 2'b00;
         vec[c].exp_tx    = (c >= 1 && c <= 40) ? txseq[(c-1)/4] : 1'b1;
      end

      // Reset held with every valid high.
      rst2_n = 1'b0; rst3_n = 1'b0;
      valid2 = 2'b11; valid3 = 3'b111;
      data2 = {8'h22, 8'h11}; data3 = {8'h33, 8'h22, 8'h11};
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         check("reset tx2", 32'(tx2), 32'd1);
         check("reset busy2", 32'(busy2), 32'd0);
         check("reset ready2", 32'(ready2), 32'd0);
         check("reset grant2", 32'(grant2), 32'd0);
         check("reset tx3", 32'(tx3), 32'd1);
         check("reset busy3", 32'(busy3), 32'd0);
         check("reset ready3", 32'(ready3), 32'd0);
         check("reset grant3", 32'(grant3), 32'd0);
      end
      @(posedge clk); #1;
      valid2 = '0; valid3 = '0;
      rst2_n = 1'b1; rst3_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single byte 0xA5 from req0, cycle by cycle.
      data2 = {8'h22, 8'hA5};
      sb_q.push_back('{data: 8'hA5, grant: 4'b0001});
      for (int c = 0; c < 43; c++) begin
         valid2 = {1'b0, vec[c].valid};
         #1;
         check($sformatf("vec%0d tx", c), 32'(tx2), 32'(vec[c].exp_tx));
         check($sformatf("vec%0d busy", c), 32'(busy2), 32'(vec[c].exp_busy));
         check($sformatf("vec%0d grant", c), 32'(grant2), 32'(vec[c].exp_grant));
         check($sformatf("vec%0d ready", c), 32'(ready2), 32'(vec[c].exp_ready));
         @(posedge clk); #1;
      end
      drain("single");

      // Two requesters contending from a fresh reset.
      rst2_n = 1'b0;
      @(posedge clk); #1;
      rst2_n = 1'b1;
      @(posedge clk); #1;
      data2 = {8'h22, 8'h11};
      start_q.delete();
      sb_q.push_back('{data: 8'h11, grant: 4'b0001});
      sb_q.push_back('{data: 8'h22, grant: 4'b0010});
      sb_q.push_back('{data: 8'h11, grant: 4'b0001});
      sb_q.push_back('{data: 8'h22, grant: 4'b0010});
      valid2 = 2'b11;
      repeat (4) wait_accept("contend");
      valid2 = 2'b00;
      drain("contend");
      check("contend frame count", 32'(start_q.size()), 32'd4);
      for (int i = 1; i < start_q.size() && i < 4; i++) begin
         check($sformatf("contend spacing %0d", i), 32'(start_q[i] - start_q[i-1]), 32'd41);
      end

      // Reset mid-frame: req1 frame abandoned during data bit 3.
      valid2 = 2'b10;
      wait_accept("midreset");
      repeat (17) @(posedge clk);
      #1;
      rst2_n = 1'b0;
      #1;
      check("midreset tx", 32'(tx2), 32'd1);
      check("midreset busy", 32'(busy2), 32'd0);
      check("midreset grant", 32'(grant2), 32'd0);
      check("midreset ready", 32'(ready2), 32'd0);
      valid2 = 2'b11;
      @(posedge clk); #1;
      rst2_n = 1'b1;
      #1;
      check("post-reset ready", 32'(ready2), 32'd1);
      sb_q.push_back('{data: 8'h11, grant: 4'b0001});
      wait_accept("post-reset");
      valid2 = 2'b00;
      drain("post-reset");

      // Rotation with three requesters.
      sel3 = 1'b1;
      @(posedge clk); #1;
      sb_q.push_back('{data: 8'h11, grant: 4'b0001});
      sb_q.push_back('{data: 8'h22, grant: 4'b0010});
      sb_q.push_back('{data: 8'h33, grant: 4'b0100});
      sb_q.push_back('{data: 8'h11, grant: 4'b0001});
      valid3 = 3'b111;
      repeat (4) wait_accept("rotate");
      valid3 = 3'b000;
      drain("rotate");

      // Fairness: req1 alone twice, then req0 and req2 arrive mid-frame.
      sb_q.push_back('{data: 8'h22, grant: 4'b0010});
      sb_q.push_back('{data: 8'h22, grant: 4'b0010});
      sb_q.push_back('{data: 8'h33, grant: 4'b0100});
      sb_q.push_back('{data: 8'h11, grant: 4'b0001});
      valid3 = 3'b010;
      wait_accept("solo1");
      wait_accept("solo2");
      valid3 = 3'b000;
      repeat (10) @(posedge clk);
      #1;
      valid3 = 3'b101;
      wait_accept("fair1");
      wait_accept("fair2");
      valid3 = 3'b000;
      drain("fair");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
